// File: rtl/tile_ram_arbiter.sv
// tile_ram_arbiter: 4-cycle slot arbiter for the tile-map RAM (VGA read, game write, full-map clear).
// Optional `TILE_ARB_GRID_EN overlays 12'h222 grid lines on tile edges.
module tile_ram_arbiter #(
  parameter int TILE_SHIFT = 4,
  parameter int MAP_W = 40,
  parameter int MAP_H = 30,
  parameter int ADDR_W = 11,
  parameter int COLOUR_W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [9:0]          pix_x,
  input  logic [9:0]          pix_y,
  output logic [COLOUR_W-1:0] pix_colour,
  input  logic                wr_req,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [COLOUR_W-1:0] wr_data,
  output logic                wr_ack,
  input  logic                clear_start,
  input  logic [COLOUR_W-1:0] clear_colour,
  output logic                clear_busy,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_we,
  output logic [COLOUR_W-1:0] ram_wdata,
  input  logic [COLOUR_W-1:0] ram_rdata
);
  localparam int TILES = MAP_W * MAP_H;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TILES - 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic [1:0] ph;
  logic [9:0] col, row;
  logic [ADDR_W-1:0] rd_addr, ptr;
  logic [COLOUR_W-1:0] colour, tile_colour;
  logic in_map, oob, slot, blocked, grant, clr_wr, accept, wr_ok;
  assign col = pix_x >> TILE_SHIFT;
  assign row = pix_y >> TILE_SHIFT;
  assign in_map = 32'(col) < MAP_W && 32'(row) < MAP_H;
  // row*40 built as (row<<5)+(row<<3)
  assign rd_addr = (ADDR_W'(row) << 5) + (ADDR_W'(row) << 3) + ADDR_W'(col);
  // slot is true on the edges that open write slots 2 and 3
  assign slot = ph == 2'd1 || ph == 2'd2;
  assign grant = state == IDLE && slot && wr_req && !blocked;
  assign clr_wr = state == CLEAR && slot;
  assign accept = state == IDLE && clear_start;
  assign wr_ok = 32'(wr_addr) < TILES;
  always_comb begin
    state_nx = state;
    state_nx = accept ? CLEAR : (clr_wr && ptr == LAST) ? IDLE : state;
  end
`ifdef TILE_ARB_GRID_EN
  logic grid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) grid <= 1'b0;
    else if (ph == 2'd3) grid <= in_map && (pix_x[TILE_SHIFT-1:0] == '0 || pix_y[TILE_SHIFT-1:0] == '0);
  assign tile_colour = oob ? '0 : grid ? COLOUR_W'(12'h222) : ram_rdata;
`else
  assign tile_colour = oob ? '0 : ram_rdata;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ph <= '0;
      state <= IDLE;
      pix_colour <= '0;
      ram_addr <= '0;
      ram_we <= 1'b0;
      ram_wdata <= '0;
      wr_ack <= 1'b0;
      clear_busy <= 1'b0;
      ptr <= '0;
      colour <= '0;
      blocked <= 1'b0;
      oob <= 1'b0;
    end else begin
      ph <= ph + 2'd1;
      state <= state_nx;
      clear_busy <= state == CLEAR || state_nx == CLEAR;
      wr_ack <= grant;
      ram_we <= clr_wr || (grant && wr_ok);
      if (slot) blocked <= grant;
      if (accept) begin
        ptr <= '0;
        colour <= clear_colour;
      end else if (clr_wr) ptr <= ptr + ADDR_W'(1);
      if (ph == 2'd3) begin
        ram_addr <= in_map ? rd_addr : '0;
        oob <= !in_map;
      end else if (clr_wr || grant) begin
        ram_addr <= clr_wr ? ptr : wr_addr;
        ram_wdata <= clr_wr ? colour : wr_data;
      end
      if (ph == 2'd1) pix_colour <= tile_colour;
    end
endmodule

// File: tb/tb_tile_ram_arbiter.sv
// tb_tile_ram_arbiter: directed bench with a synchronous RAM model and a pixel-colour scoreboard.
`timescale 1ns/1ps
module tb_tile_ram_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [9:0] pix_x = '0, pix_y = '0;
  logic [11:0] pix_colour, ram_wdata, ram_rdata;
  logic [11:0] wr_data = '0, clear_colour = '0;
  logic wr_req = 1'b0, clear_start = 1'b0;
  logic wr_ack, clear_busy, ram_we;
  logic [10:0] wr_addr = '0, ram_addr;
  logic pre_we = 1'b0;
  logic [10:0] pre_addr = '0;
  logic [11:0] pre_data = '0;
  logic [11:0] mem [2048];
  logic [1:0] tph;
  logic [11:0] exp_q [$];
  int checks = 0, errors = 0;
`ifdef TILE_ARB_GRID_EN
  localparam logic [11:0] GRID_EXP = 12'h222;
`else
  localparam logic [11:0] GRID_EXP = 12'hABC;
`endif

  tile_ram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .clear_start(clear_start), .clear_colour(clear_colour), .clear_busy(clear_busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // independent model of the slot phase
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tph <= 2'd0;
    else tph <= tph + 2'd1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic at_ph(input logic [1:0] k);
    @(negedge clk);
    while (tph != k) @(negedge clk);
  endtask

  task automatic preload(input logic [10:0] a, input logic [11:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic [10:0] a, input logic [11:0] c);
    at_ph(3);
    pix_x = x;
    pix_y = y;
    exp_q.push_back(c);
    at_ph(0);
    chk({tag, "_addr"}, ram_addr, a);
    at_ph(2);
    chk({tag, "_pix"}, pix_colour, exp_q.pop_front());
  endtask

  initial begin
    int n, acks, bad_we, bad;
    @(negedge clk);
    preload(11'd0, 12'hF00);
    preload(11'd1, 12'hABC);
    preload(11'd1199, 12'h123);
    chk("rst_pix", pix_colour, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_ack", wr_ack, 0);
    chk("rst_busy", clear_busy, 0);
    exp_q.push_back(12'hF00);
    rst_n = 1'b1;
    at_ph(2);
    chk("first_pix", pix_colour, exp_q.pop_front());
    pixel("last_tile", 10'd639, 10'd479, 11'd1199, 12'h123);
    pixel("off_map", 10'd645, 10'd0, 11'd0, 12'h000);
    pixel("grid_pt", 10'd16, 10'd5, 11'd1, GRID_EXP);
    // held write request: one grant in slot 2, slot 3 blocked
    at_ph(0);
    wr_req = 1'b1;
    wr_addr = 11'd41;
    wr_data = 12'h0F0;
    at_ph(1);
    chk("wr_ack_ph1", wr_ack, 0);
    at_ph(2);
    chk("wr_ack_ph2", wr_ack, 1);
    chk("wr_we_ph2", ram_we, 1);
    chk("wr_addr_ph2", ram_addr, 41);
    chk("wr_data_ph2", ram_wdata, 12'h0F0);
    at_ph(3);
    chk("wr_ack_ph3", wr_ack, 0);
    chk("wr_we_ph3", ram_we, 0);
    wr_req = 1'b0;
    pixel("readback41", 10'd20, 10'd20, 11'd41, 12'h0F0);
    // out-of-map write is acked but dropped
    at_ph(0);
    wr_req = 1'b1;
    wr_addr = 11'd1200;
    wr_data = 12'h777;
    at_ph(2);
    chk("drop_ack", wr_ack, 1);
    chk("drop_we", ram_we, 0);
    wr_req = 1'b0;
    // full clear with a competing write request held high
    at_ph(3);
    clear_start = 1'b1;
    clear_colour = 12'h00F;
    wr_req = 1'b1;
    wr_addr = 11'd5;
    wr_data = 12'hFFF;
    @(negedge clk);
    n = 0;
    acks = 0;
    bad_we = 0;
    while (clear_busy && n < 3000) begin
      n++;
      acks += int'(wr_ack);
      if (tph < 2'd2 && ram_we) bad_we++;
      clear_start = (n == 1000);
      if (n == 1000) clear_colour = 12'hF0F;
      @(negedge clk);
    end
    clear_start = 1'b0;
    chk("clr_busy_cycles", n, 2400);
    chk("clr_acks_during", acks, 0);
    chk("clr_we_read_slot", bad_we, 0);
    n = 0;
    while (!wr_ack && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("post_clr_ack", wr_ack, 1);
    chk("ack_after_busy", clear_busy, 0);
    wr_req = 1'b0;
    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 1200; i++)
      if (i != 5 && mem[i] !== 12'h00F) bad++;
    chk("clr_tiles", bad, 0);
    chk("post_clr_tile5", mem[5], 12'hFFF);
    // reset in the middle of a sweep
    at_ph(3);
    clear_start = 1'b1;
    clear_colour = 12'h0F0;
    @(negedge clk);
    clear_start = 1'b0;
    chk("mid_busy", clear_busy, 1);
    repeat (1200) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", clear_busy, 0);
    chk("mid_rst_we", ram_we, 0);
    chk("mid_rst_addr", ram_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr_req = 1'b1;
    wr_addr = 11'd7;
    wr_data = 12'h0AA;
    @(negedge clk);
    chk("after_rst_busy", clear_busy, 0);
    n = 0;
    while (!wr_ack && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("after_rst_ack", wr_ack, 1);
    wr_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("after_rst_tile7", mem[7], 12'h0AA);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tile_ram_arbiter.md
# tile_ram_arbiter

Time-slot arbiter and sequencer for the single-port tile-map RAM behind the Snake VGA output. Each 4-cycle pixel period is split into one read slot for the VGA scan and two write slots, shared by the game-logic writer and a built-in full-map clear engine. The block's pixel output is the colour that feeds `vga_control`'s COLOUR_IN.

## Interface
- TILE_SHIFT, 4, log2 of tile edge in pixels (16×16 tiles)
- MAP_W, 40, tiles per row
- MAP_H, 30, tile rows
- ADDR_W, 11, RAM address width
- COLOUR_W, 12, colour width

- CLK  in  1  system clock (100 MHz)
- RESETN  in  1  asynchronous active-low reset
- PIX_X  in  10  visible-area pixel column from VGA controller
- PIX_Y  in  10  visible-area pixel row from VGA controller
- PIX_COLOUR  out  COLOUR_W  registered tile colour for current pixel
- WR_REQ  in  1  game-logic write request, level, held until WR_ACK
- WR_ADDR  in  ADDR_W  tile index, row*MAP_W+col
- WR_DATA  in  COLOUR_W  tile colour
- WR_ACK  out  1  one-cycle grant pulse
- CLEAR_START  in  1  pulse: fill whole map with CLEAR_COLOUR
- CLEAR_COLOUR  in  COLOUR_W  fill colour, sampled on accepted CLEAR_START
- CLEAR_BUSY  out  1  high while clear sweep runs
- RAM_ADDR  out  ADDR_W  registered RAM address
- RAM_WE  out  1  registered write enable
- RAM_WDATA  out  COLOUR_W  registered write data
- RAM_RDATA  in  COLOUR_W  RAM read data, valid 1 cycle after address

## Operation
- Free-running 2-bit phase counter `ph`, 0→1→2→3→0.
- Reset values: ph=0; PIX_COLOUR, RAM_ADDR, RAM_WDATA = 0; RAM_WE, WR_ACK, CLEAR_BUSY = 0; FSM in IDLE.
- Read address = (PIX_Y>>TILE_SHIFT)*MAP_W + (PIX_X>>TILE_SHIFT). Use shift-add (×40 = <<5 + <<3), ADDR_W-bit result.
- Out-of-map pixels (col ≥ MAP_W or row ≥ MAP_H): RAM_ADDR = 0 and PIX_COLOUR = 0 for that pixel.
- FSM IDLE, slot ph=2 or 3:
  - WR_REQ high and not blocked: RAM_WE=1, RAM_ADDR=WR_ADDR, RAM_WDATA=WR_DATA, WR_ACK=1 in the same cycle.
  - A write slot immediately after an acked slot is never granted, so a still-high WR_REQ is not double-written. Maximum rate is one game write per 4 cycles.
  - WR_ADDR ≥ MAP_W*MAP_H: request is acked, but RAM_WE stays 0 (write dropped).
- CLEAR_START in IDLE → CLEAR next cycle. CLEAR_BUSY=1, pointer=0, colour latched.
- FSM CLEAR: every write slot (ph=2 and ph=3) writes the latched colour at the pointer, then increments it. After writing MAP_W*MAP_H−1 → IDLE; CLEAR_BUSY falls the following cycle.
  - WR_REQ is stalled (no ack) during CLEAR.
  - CLEAR_START during CLEAR is ignored.
  - Full sweep takes 2400 cycles at default parameters.
- The read slot is never preempted. RAM_WE=0 in ph=0 and ph=1 regardless of FSM state.
- RESETN asserted mid-clear or mid-grant: immediate return to reset values, sweep abandoned, RAM contents undefined.

## Timing
- Registered outputs: during the cycle where ph=k, RAM_* show slot k's access.
- PIX_X/PIX_Y sampled on the edge ending ph=3. Read address on RAM_ADDR during ph=0. RAM_RDATA captured on the edge ending ph=1.
- PIX_COLOUR updates on the edge entering ph=2 and holds for 4 cycles. Latency is 3 edges from sample to PIX_COLOUR.
- WR_ACK is high in exactly the cycle where RAM_WE carries that write (or would, if dropped).

## Configuration
- `TILE_ARB_GRID_EN` defined: pixels with PIX_X[TILE_SHIFT-1:0]==0 or PIX_Y[TILE_SHIFT-1:0]==0 inside the map output 12'h222 instead of tile colour. The low bits are pipelined alongside the read, with identical latency.
- Undefined: PIX_COLOUR is always the tile colour (or 0 when out of map); no grid logic is present.

## Test plan
- Reset release, PIX_X=0, PIX_Y=0, RAM preloaded tile 0=12'hF00 → PIX_COLOUR=12'hF00 on first ph=2 edge; all outputs 0 before release.
- PIX_X=639, PIX_Y=479 → RAM_ADDR=1199 in ph=0. PIX_X=645 → PIX_COLOUR=0.
- WR_REQ held with WR_ADDR=41, WR_DATA=12'h0F0 → single WR_ACK, single RAM_WE in ph=2, no write in ph=3. Readback of tile 41=12'h0F0.
- CLEAR_START with CLEAR_COLOUR=12'h00F, WR_REQ high throughout → CLEAR_BUSY for 2400 cycles, all 1200 tiles = 12'h00F, WR_ACK only after CLEAR_BUSY falls.
- WR_ADDR=1200 → WR_ACK pulses, RAM_WE stays 0. RESETN pulsed at pointer 600 → CLEAR_BUSY=0 immediately, FSM IDLE.
- With `TILE_ARB_GRID_EN`, PIX_X=16, PIX_Y=5 → PIX_COLOUR=12'h222. Without it → tile colour.
